// File: rtl/fixnfloat_pkg.sv
// fixnfloat_pkg: shared widths, opcodes and tag types for the converter arbiter
package fixnfloat_pkg;
    localparam int DATA_W = 32;
    localparam int POS_W  = 5;
    localparam logic OPC_FIX2FLT = 1'b0;
    localparam logic OPC_FLT2FIX = 1'b1;
    typedef logic req_id_t;
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/fixnfloat_tag_pipe.sv
// fixnfloat_tag_pipe: {valid,id} delay line matching the converter latency
module fixnfloat_tag_pipe
    import fixnfloat_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign tag_out   = tag_in;
            assign any_valid = 1'b0;
        end else begin : g_shift
            tag_t stage [DEPTH];
            // shift one stage per cycle; idle cycles push bubbles through
            always_ff @(posedge clk or posedge rst)
                if (rst)
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                else begin
                    stage[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            // any stage holding a live tag means work in flight
            always_comb begin
                any_valid = 1'b0;
                for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
            end
            assign tag_out = stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/fixnfloat_arbiter.sv
// fixnfloat_arbiter: round-robin sharing of one fixnfloat converter between two requesters
module fixnfloat_arbiter
    import fixnfloat_pkg::*;
#(
    parameter int CONV_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_number,
    input  logic [POS_W-1:0]  req0_fixpointpos,
    input  logic              req0_opcode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_number,
    input  logic [POS_W-1:0]  req1_fixpointpos,
    input  logic              req1_opcode,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [DATA_W-1:0] conv_targetnumber,
    output logic [POS_W-1:0]  conv_fixpointpos,
    output logic              conv_opcode,
    input  logic [DATA_W-1:0] conv_result,
    output logic              busy
);
    req_id_t last;
    logic    g0, g1, xfer, pipe_busy;
    tag_t    iss_tag, conv_tag;

    // when both ask, the requester not served last wins; nothing granted in reset
    always_comb begin
        g0 = !rst && req0_valid && (!req1_valid || last);
        g1 = !rst && req1_valid && (!req0_valid || !last);
        xfer = g0 || g1;
    end

    assign req0_ready = g0;
    assign req1_ready = g1;

    // last-granted pointer; reset value makes req0 win the first contention
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last <= 1'b1;
        else if (xfer)
            last <= g1;

    // register the winning operand onto the converter and launch its tag
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            conv_targetnumber <= '0;
            conv_fixpointpos  <= '0;
            conv_opcode       <= 1'b0;
            iss_tag           <= '0;
        end else begin
            iss_tag <= '{valid: xfer, id: g1};
            if (xfer) begin
                conv_targetnumber <= g1 ? req1_number      : req0_number;
                conv_fixpointpos  <= g1 ? req1_fixpointpos : req0_fixpointpos;
                conv_opcode       <= g1 ? req1_opcode      : req0_opcode;
            end
        end

    fixnfloat_tag_pipe #(.DEPTH(CONV_LATENCY)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (iss_tag),
        .tag_out   (conv_tag),
        .any_valid (pipe_busy)
    );

    // steer the converter result to its owner as a one-cycle pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            rsp0_valid <= conv_tag.valid && !conv_tag.id;
            rsp1_valid <= conv_tag.valid && conv_tag.id;
            if (conv_tag.valid && !conv_tag.id) rsp0_result <= conv_result;
            if (conv_tag.valid && conv_tag.id)  rsp1_result <= conv_result;
        end

    assign busy = iss_tag.valid || pipe_busy;
endmodule

// File: tb/tb_fixnfloat_arbiter.sv
// tb_fixnfloat_arbiter: scoreboard bench with a behavioural fixnfloat converter behind the arbiter
module tb_fixnfloat_arbiter;
    import fixnfloat_pkg::*;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [31:0] req0_number = '0, req1_number = '0;
    logic [4:0] req0_fixpointpos = '0, req1_fixpointpos = '0;
    logic req0_opcode = 1'b0, req1_opcode = 1'b0;
    logic rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] conv_targetnumber;
    logic [4:0] conv_fixpointpos;
    logic conv_opcode;
    logic [31:0] conv_result = '0;
    logic busy;

    logic [31:0] exp0 = '0, exp1 = '0;
    logic [63:0] q0[$], q1[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    fixnfloat_arbiter #(.CONV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_number(req0_number),
        .req0_fixpointpos(req0_fixpointpos), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_number(req1_number),
        .req1_fixpointpos(req1_fixpointpos), .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .conv_targetnumber(conv_targetnumber), .conv_fixpointpos(conv_fixpointpos),
        .conv_opcode(conv_opcode), .conv_result(conv_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fix2flt(input logic [31:0] x, input logic [4:0] pos);
        logic s;
        logic [31:0] m, t;
        int p, e;
        if (x == 0) return 32'h0;
        s = x[31];
        m = s ? -x : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = p - int'(pos) + 127;
        t = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
        return {s, 8'(e), t[22:0]};
    endfunction

    function automatic logic [31:0] flt2fix(input logic [31:0] f, input logic [4:0] pos);
        logic [31:0] m, v;
        int sh;
        if (f[30:23] == 0) return 32'h0;
        m = {8'h0, 1'b1, f[22:0]};
        sh = int'(f[30:23]) - 150 + int'(pos);
        v = (sh >= 0) ? (m << sh) : (m >> (-sh));
        return f[31] ? -v : v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        conv_result <= (conv_opcode == OPC_FLT2FIX) ? flt2fix(conv_targetnumber, conv_fixpointpos)
                                                    : fix2flt(conv_targetnumber, conv_fixpointpos);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        logic [63:0] e;
        if (rsp0_valid) begin
            if (q0.size() == 0) chk("rsp0_spurious", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("rsp0_result", rsp0_result, e[31:0]);
                chk("rsp0_latency", 32'(cyc) - e[63:32], 32'(LAT + 2));
            end
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) chk("rsp1_spurious", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("rsp1_result", rsp1_result, e[31:0]);
                chk("rsp1_latency", 32'(cyc) - e[63:32], 32'(LAT + 2));
            end
        end
        if (req0_valid && req0_ready) q0.push_back({32'(cyc), exp0});
        if (req1_valid && req1_ready) q1.push_back({32'(cyc), exp1});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [31:0] n, input logic [4:0] p, input logic o, input logic [31:0] e);
        req0_valid = 1'b1; req0_number = n; req0_fixpointpos = p; req0_opcode = o; exp0 = e;
    endtask

    task automatic set1(input logic [31:0] n, input logic [4:0] p, input logic o, input logic [31:0] e);
        req1_valid = 1'b1; req1_number = n; req1_fixpointpos = p; req1_opcode = o; exp1 = e;
    endtask

    logic [31:0] t4_num [4] = '{32'hFFFFFFA0, 32'h0, 32'hFFFFFBE0, 32'hC17C0000};
    logic [31:0] t4_exp [4] = '{32'hBF400000, 32'h0, 32'hC1040000, 32'hFFFFF820};
    logic        t4_op  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // reset with both requesters valid
        set0(32'd1056, 5'd7, OPC_FIX2FLT, 32'h41040000);
        set1(32'hFFFFFFA0, 5'd7, OPC_FIX2FLT, 32'hBF400000);
        repeat (3) step();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conv_num", conv_targetnumber, 32'd0);
        chk("rst_conv_pos_op", {26'd0, conv_fixpointpos, conv_opcode}, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_grant0", 32'(req0_ready), 32'd1);
        chk("first_grant1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();

        // req0 alone
        set0(32'd1056, 5'd7, OPC_FIX2FLT, 32'h41040000);
        #1 chk("t2_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        repeat (3) step();

        // req1 back-to-back
        for (int i = 0; i < 4; i++) begin
            set1(t4_num[i], 5'd7, t4_op[i], t4_exp[i]);
            #1 chk("t4_ready1", 32'(req1_ready), 32'd1);
            step();
        end
        req1_valid = 1'b0;
        repeat (4) step();

        // contention alternates
        set0(32'd2016, 5'd7, OPC_FIX2FLT, 32'h417C0000);
        set1(32'h3F400000, 5'd7, OPC_FLT2FIX, 32'h00000060);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_grant0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("t3_grant1", 32'(req1_ready), 32'((i % 2) == 1));
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // reset while an operation is in flight
        set0(32'h3F400000, 5'd7, OPC_FLT2FIX, 32'h00000060);
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #2;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp0", 32'(rsp0_valid), 32'd0);
        step();
        rst = 1'b0;
        set0(32'd96, 5'd7, OPC_FIX2FLT, 32'h3F400000);
        #1 chk("t5_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        repeat (4) step();

        // transfers every third cycle
        for (int i = 0; i < 3; i++) begin
            logic [31:0] n;
            n = (i == 1) ? 32'hC17C0000 : 32'd1056 + 32'(i);
            if (i == 1) set1(n, 5'd7, OPC_FLT2FIX, 32'hFFFFF820);
            else set0(n, 5'd7, OPC_FIX2FLT, (i == 0) ? 32'h41040000 : 32'h41044000);
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #2 chk("t6_busy_issue", 32'(busy), 32'd1);
            chk("t6_conv_num", conv_targetnumber, n);
            step();
            #2 chk("t6_busy_conv", 32'(busy), 32'd1);
            step();
            #2 chk("t6_busy_idle", 32'(busy), 32'd0);
            chk("t6_conv_hold", conv_targetnumber, n);
        end

        // drain with a bounded wait
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) step();
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
